// File: rtl/ddr_qm_pkg.sv
// Shared definitions for the multi-queue DDR manager: beat/byte scaling, descriptor layout
// and read-engine state encoding.
package ddr_qm_pkg;

    localparam int unsigned BeatShift = 3;
    localparam int unsigned LenW      = 16;
    localparam int unsigned StrbW     = 8;
    localparam int unsigned DescMetaW = LenW + StrbW;

    // Descriptor packing is {len, strb, addr}, addr in the low bits.
    function automatic int unsigned desc_width(input int unsigned addr_w);
        return DescMetaW + addr_w;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StIssue,
        StDone
    } rd_state_e;

endpackage

// File: rtl/ddr_desc_fifo.sv
// First-word-fall-through synchronous FIFO holding completed-write descriptors for one queue.
module ddr_desc_fifo #(
    parameter int unsigned Width = 56,
    parameter int unsigned Depth = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic [Width-1:0] o_data,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    // Extra pointer bit distinguishes full from empty.
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (i_push && !o_full) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (i_pop && !o_empty) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ddr_multi_queue_mgr.sv
// Multi-queue DDR ring allocator: per-queue write-address allocation with wrap/back-pressure,
// completion descriptor FIFOs, and a budget-driven read descriptor engine.
module ddr_multi_queue_mgr
    import ddr_qm_pkg::*;
#(
    parameter int unsigned P_BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned P_ADDR_WIDTH    = 32,
    parameter int unsigned P_QUEUE_NUM     = 4,
    parameter int unsigned P_REGION_BYTES  = 32'h0040_0000,
    parameter int unsigned P_DESC_DEPTH    = 1024,
    parameter int unsigned P_MAX_PKT_BYTES = 1518,
    localparam int unsigned QW = $clog2(P_QUEUE_NUM),
    localparam int unsigned W  = P_ADDR_WIDTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_req_valid,
    input  logic [QW-1:0]            i_wr_req_qid,
    input  logic [15:0]              i_wr_req_len,
    output logic                     o_wr_req_ready,
    output logic                     o_wr_alloc_valid,
    output logic [W-1:0]             o_wr_alloc_addr,
    input  logic                     i_wr_cpl_valid,
    output logic                     o_wr_cpl_ready,
    input  logic [QW-1:0]            i_wr_cpl_qid,
    input  logic [W-1:0]             i_wr_cpl_addr,
    input  logic [15:0]              i_wr_cpl_len,
    input  logic [7:0]               i_wr_cpl_strb,
    input  logic                     i_rd_budget_valid,
    output logic                     o_rd_budget_ready,
    input  logic [QW-1:0]            i_rd_budget_qid,
    input  logic [W-1:0]             i_rd_budget_bytes,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic [W-1:0]             o_rd_addr,
    output logic [15:0]              o_rd_len,
    output logic [7:0]               o_rd_strb,
    output logic [QW-1:0]            o_rd_qid,
    output logic                     o_rd_done,
    output logic [W-1:0]             o_rd_done_bytes,
    output logic [P_QUEUE_NUM*W-1:0] o_queue_size
);

    localparam int unsigned DW          = desc_width(W);
    localparam logic [W-1:0] RegionBytes = W'(P_REGION_BYTES);
    localparam logic [W-1:0] MaxPktBytes = W'(P_MAX_PKT_BYTES);

    function automatic logic [W-1:0] region_base(input logic [QW-1:0] qid);
        return W'(P_BASE_ADDR) + W'(qid) * RegionBytes;
    endfunction

    logic [W-1:0] wptr_q [P_QUEUE_NUM];
    logic [W-1:0] wptr_d [P_QUEUE_NUM];
    logic [W-1:0] used_q [P_QUEUE_NUM];
    logic [W-1:0] used_d [P_QUEUE_NUM];
    logic [W-1:0] size_q [P_QUEUE_NUM];
    logic [W-1:0] size_d [P_QUEUE_NUM];
    logic [W-1:0] pad_q  [P_QUEUE_NUM];
    logic [W-1:0] pad_d  [P_QUEUE_NUM];
    logic [P_QUEUE_NUM-1:0] pad_v_q, pad_v_d;

    logic [DW-1:0]          fifo_data [P_QUEUE_NUM];
    logic [P_QUEUE_NUM-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;

    rd_state_e    state_q, state_d;
    logic [QW-1:0] rd_qid_q, rd_qid_d;
    logic [W-1:0] budget_q, budget_d, issued_q, issued_d;

    logic [W-1:0] req_bytes, req_base, req_room, req_skip, alloc_start;
    logic         req_wrap;
    logic         cpl_accept, rd_pop, pad_hit;
    logic [W-1:0] cpl_bytes, head_addr, head_bytes;
    logic [15:0]  head_len;
    logic [7:0]   head_strb;

    always_comb begin
        req_bytes      = W'(i_wr_req_len) << BeatShift;
        req_base       = region_base(i_wr_req_qid);
        req_room       = req_base + RegionBytes - wptr_q[i_wr_req_qid];
        req_wrap       = req_room < req_bytes;
        req_skip       = req_wrap ? req_room : '0;
        alloc_start    = req_wrap ? req_base : wptr_q[i_wr_req_qid];
        o_wr_req_ready = i_wr_req_valid && (i_wr_req_len != '0) &&
                         (used_q[i_wr_req_qid] + req_bytes + req_skip <= RegionBytes);
    end

    assign o_wr_cpl_ready = !fifo_full[i_wr_cpl_qid];
    assign cpl_accept     = i_wr_cpl_valid && o_wr_cpl_ready;
    assign cpl_bytes      = W'(i_wr_cpl_len) << BeatShift;

    assign {head_len, head_strb, head_addr} = fifo_data[rd_qid_q];
    assign head_bytes = W'(head_len) << BeatShift;
    assign rd_pop     = (state_q == StIssue) && i_rd_ready;
    // The skipped tail gap is returned with the first buffer read back from the region base.
    assign pad_hit    = pad_v_q[rd_qid_q] && (head_addr == region_base(rd_qid_q));

    for (genvar g = 0; g < P_QUEUE_NUM; g++) begin : g_fifo
        assign fifo_push[g] = cpl_accept && (i_wr_cpl_qid == QW'(g));
        assign fifo_pop[g]  = rd_pop && (rd_qid_q == QW'(g));

        ddr_desc_fifo #(
            .Width (DW),
            .Depth (P_DESC_DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_push  (fifo_push[g]),
            .i_data  ({i_wr_cpl_len, i_wr_cpl_strb, i_wr_cpl_addr}),
            .o_full  (fifo_full[g]),
            .i_pop   (fifo_pop[g]),
            .o_data  (fifo_data[g]),
            .o_empty (fifo_empty[g])
        );

        assign o_queue_size[g*W +: W] = size_q[g];
    end

    always_comb begin
        pad_v_d = pad_v_q;
        for (int q = 0; q < P_QUEUE_NUM; q++) begin
            wptr_d[q] = wptr_q[q];
            used_d[q] = used_q[q];
            size_d[q] = size_q[q];
            pad_d[q]  = pad_q[q];
            if (fifo_pop[q]) begin
                used_d[q] = used_d[q] - head_bytes - (pad_hit ? pad_q[q] : '0);
                size_d[q] = size_d[q] - head_bytes;
                if (pad_hit) pad_v_d[q] = 1'b0;
            end
            if (o_wr_req_ready && (i_wr_req_qid == QW'(q))) begin
                used_d[q] = used_d[q] + req_bytes + req_skip;
                wptr_d[q] = alloc_start + req_bytes;
                if (req_wrap) begin
                    pad_d[q]   = req_skip;
                    pad_v_d[q] = 1'b1;
                end
            end
            if (fifo_push[q]) size_d[q] = size_d[q] + cpl_bytes;
        end
    end

    always_comb begin
        state_d           = state_q;
        rd_qid_d          = rd_qid_q;
        budget_d          = budget_q;
        issued_d          = issued_q;
        o_rd_budget_ready = 1'b0;
        o_rd_valid        = 1'b0;
        o_rd_done         = 1'b0;
        o_rd_done_bytes   = '0;
        case (state_q)
            StIdle: begin
                o_rd_budget_ready = 1'b1;
                if (i_rd_budget_valid) begin
                    rd_qid_d = i_rd_budget_qid;
                    budget_d = i_rd_budget_bytes;
                    issued_d = '0;
                    state_d  = StFetch;
                end
            end
            StFetch: begin
                if (fifo_empty[rd_qid_q] || (head_bytes > budget_q - issued_q)) state_d = StDone;
                else state_d = StIssue;
            end
            StIssue: begin
                o_rd_valid = 1'b1;
                if (i_rd_ready) begin
                    issued_d = issued_q + head_bytes;
                    state_d  = StFetch;
                end
            end
            StDone: begin
                o_rd_done       = 1'b1;
                o_rd_done_bytes = issued_q;
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_rd_addr = o_rd_valid ? head_addr : '0;
    assign o_rd_len  = o_rd_valid ? head_len : '0;
    assign o_rd_strb = o_rd_valid ? head_strb : '0;
    assign o_rd_qid  = o_rd_valid ? rd_qid_q : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q          <= StIdle;
            rd_qid_q         <= '0;
            budget_q         <= '0;
            issued_q         <= '0;
            o_wr_alloc_valid <= 1'b0;
            o_wr_alloc_addr  <= '0;
            pad_v_q          <= '0;
            for (int q = 0; q < P_QUEUE_NUM; q++) begin
                wptr_q[q] <= region_base(QW'(q));
                used_q[q] <= '0;
                size_q[q] <= '0;
                pad_q[q]  <= '0;
            end
        end else begin
            state_q          <= state_d;
            rd_qid_q         <= rd_qid_d;
            budget_q         <= budget_d;
            issued_q         <= issued_d;
            o_wr_alloc_valid <= o_wr_req_ready;
            if (o_wr_req_ready) o_wr_alloc_addr <= alloc_start;
            pad_v_q          <= pad_v_d;
            for (int q = 0; q < P_QUEUE_NUM; q++) begin
                wptr_q[q] <= wptr_d[q];
                used_q[q] <= used_d[q];
                size_q[q] <= size_d[q];
                pad_q[q]  <= pad_d[q];
            end
        end
    end

    // Upstream must never complete a buffer larger than the largest packet.
    assert property (@(posedge i_clk) disable iff (i_rst) cpl_accept |-> cpl_bytes <= MaxPktBytes);

endmodule

// File: tb/tb_ddr_multi_queue_mgr.sv
// Directed bench for ddr_multi_queue_mgr: table-driven allocation vectors plus hand-written
// wrap, back-pressure, read-budget, stall and reset sequences.
module tb_ddr_multi_queue_mgr;

    localparam int unsigned W      = 32;
    localparam int unsigned Q      = 4;
    localparam int unsigned QW     = 2;
    localparam int unsigned BASE   = 32'h0000_0000;
    localparam int unsigned REGION = 32'h0000_0400;
    localparam int unsigned DEPTH  = 16;

    logic          i_clk, i_rst;
    logic          i_wr_req_valid;
    logic [QW-1:0] i_wr_req_qid;
    logic [15:0]   i_wr_req_len;
    logic          o_wr_req_ready, o_wr_alloc_valid;
    logic [W-1:0]  o_wr_alloc_addr;
    logic          i_wr_cpl_valid, o_wr_cpl_ready;
    logic [QW-1:0] i_wr_cpl_qid;
    logic [W-1:0]  i_wr_cpl_addr;
    logic [15:0]   i_wr_cpl_len;
    logic [7:0]    i_wr_cpl_strb;
    logic          i_rd_budget_valid, o_rd_budget_ready;
    logic [QW-1:0] i_rd_budget_qid;
    logic [W-1:0]  i_rd_budget_bytes;
    logic          o_rd_valid, i_rd_ready;
    logic [W-1:0]  o_rd_addr;
    logic [15:0]   o_rd_len;
    logic [7:0]    o_rd_strb;
    logic [QW-1:0] o_rd_qid;
    logic          o_rd_done;
    logic [W-1:0]  o_rd_done_bytes;
    logic [Q*W-1:0] o_queue_size;

    int total = 0;
    int bad   = 0;

    ddr_multi_queue_mgr #(
        .P_BASE_ADDR     (BASE),
        .P_ADDR_WIDTH    (W),
        .P_QUEUE_NUM     (Q),
        .P_REGION_BYTES  (REGION),
        .P_DESC_DEPTH    (DEPTH),
        .P_MAX_PKT_BYTES (1518)
    ) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_wr_req_valid    (i_wr_req_valid),
        .i_wr_req_qid      (i_wr_req_qid),
        .i_wr_req_len      (i_wr_req_len),
        .o_wr_req_ready    (o_wr_req_ready),
        .o_wr_alloc_valid  (o_wr_alloc_valid),
        .o_wr_alloc_addr   (o_wr_alloc_addr),
        .i_wr_cpl_valid    (i_wr_cpl_valid),
        .o_wr_cpl_ready    (o_wr_cpl_ready),
        .i_wr_cpl_qid      (i_wr_cpl_qid),
        .i_wr_cpl_addr     (i_wr_cpl_addr),
        .i_wr_cpl_len      (i_wr_cpl_len),
        .i_wr_cpl_strb     (i_wr_cpl_strb),
        .i_rd_budget_valid (i_rd_budget_valid),
        .o_rd_budget_ready (o_rd_budget_ready),
        .i_rd_budget_qid   (i_rd_budget_qid),
        .i_rd_budget_bytes (i_rd_budget_bytes),
        .o_rd_valid        (o_rd_valid),
        .i_rd_ready        (i_rd_ready),
        .o_rd_addr         (o_rd_addr),
        .o_rd_len          (o_rd_len),
        .o_rd_strb         (o_rd_strb),
        .o_rd_qid          (o_rd_qid),
        .o_rd_done         (o_rd_done),
        .o_rd_done_bytes   (o_rd_done_bytes),
        .o_queue_size      (o_queue_size)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, want summary");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [QW-1:0] qid;
        logic [15:0]   len;
        logic          exp_ready;
        logic [W-1:0]  exp_addr;
        string         name;
    } alloc_vec_t;

    alloc_vec_t vecs [7];

    function automatic logic [W-1:0] rbase(input int q);
        return W'(BASE) + W'(q) * W'(REGION);
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic qsize_check(input string name, input int q, input logic [W-1:0] exp);
        check(name, 64'(o_queue_size[q*W +: W]), 64'(exp));
    endtask

    task automatic do_alloc(input int q, input int len, input logic exp_ready,
                            input logic [W-1:0] exp_addr, input string name);
        i_wr_req_valid = 1'b1;
        i_wr_req_qid   = QW'(q);
        i_wr_req_len   = 16'(len);
        #2;
        check({name, "_ready"}, 64'(o_wr_req_ready), 64'(exp_ready));
        tick();
        i_wr_req_valid = 1'b0;
        check({name, "_avalid"}, 64'(o_wr_alloc_valid), 64'(exp_ready));
        if (exp_ready) check({name, "_addr"}, 64'(o_wr_alloc_addr), 64'(exp_addr));
    endtask

    task automatic do_cpl(input int q, input logic [W-1:0] addr, input int len,
                          input logic [7:0] strb);
        i_wr_cpl_valid = 1'b1;
        i_wr_cpl_qid   = QW'(q);
        i_wr_cpl_addr  = addr;
        i_wr_cpl_len   = 16'(len);
        i_wr_cpl_strb  = strb;
        #2;
        check("cpl_ready", 64'(o_wr_cpl_ready), 64'd1);
        tick();
        i_wr_cpl_valid = 1'b0;
    endtask

    // Grant a budget with i_rd_ready held high, count issued descriptors until o_rd_done.
    task automatic run_read(input int q, input int budget, input int exp_n, input int exp_bytes,
                            input string name);
        int cyc, n, first;
        bit done;
        check({name, "_bready"}, 64'(o_rd_budget_ready), 64'd1);
        i_rd_budget_valid = 1'b1;
        i_rd_budget_qid   = QW'(q);
        i_rd_budget_bytes = W'(budget);
        tick();
        i_rd_budget_valid = 1'b0;
        cyc = 1; n = 0; first = -1; done = 1'b0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
            if (o_rd_valid) begin
                if (first < 0) first = cyc;
                n++;
            end
            if (o_rd_done) begin
                done = 1'b1;
                check({name, "_dbytes"}, 64'(o_rd_done_bytes), 64'(exp_bytes));
            end
        end
        check({name, "_done_seen"}, 64'(done), 64'd1);
        check({name, "_ndesc"}, 64'(n), 64'(exp_n));
        if (exp_n > 0) check({name, "_lat"}, 64'(first), 64'd2);
        else check({name, "_donelat"}, 64'(cyc), 64'd2);
    endtask

    initial begin
        i_rst = 1'b1;
        i_wr_req_valid = 1'b0; i_wr_req_qid = '0; i_wr_req_len = '0;
        i_wr_cpl_valid = 1'b0; i_wr_cpl_qid = '0; i_wr_cpl_addr = '0;
        i_wr_cpl_len = '0; i_wr_cpl_strb = '0;
        i_rd_budget_valid = 1'b0; i_rd_budget_qid = '0; i_rd_budget_bytes = '0;
        i_rd_ready = 1'b1;

        vecs[0] = '{qid: 2'd0, len: 16'd8,    exp_ready: 1'b1, exp_addr: rbase(0),         name: "t1_q0_a"};
        vecs[1] = '{qid: 2'd0, len: 16'd8,    exp_ready: 1'b1, exp_addr: rbase(0) + 'h40,  name: "t1_q0_b"};
        vecs[2] = '{qid: 2'd1, len: 16'd8,    exp_ready: 1'b1, exp_addr: rbase(1),         name: "t1_q1"};
        vecs[3] = '{qid: 2'd0, len: 16'd0,    exp_ready: 1'b0, exp_addr: '0,               name: "t1_len0"};
        vecs[4] = '{qid: 2'd3, len: 16'h80,   exp_ready: 1'b1, exp_addr: rbase(3),         name: "t1_q3_fill"};
        vecs[5] = '{qid: 2'd3, len: 16'd1,    exp_ready: 1'b0, exp_addr: '0,               name: "t1_q3_full"};
        vecs[6] = '{qid: 2'd2, len: 16'h81,   exp_ready: 1'b0, exp_addr: '0,               name: "t1_q2_big"};

        repeat (2) tick();
        check("rst_bready", 64'(o_rd_budget_ready), 64'd1);
        check("rst_rvalid", 64'(o_rd_valid), 64'd0);
        check("rst_avalid", 64'(o_wr_alloc_valid), 64'd0);
        check("rst_done", 64'(o_rd_done), 64'd0);
        check("rst_qsize", 64'(o_queue_size != '0), 64'd0);
        i_rst = 1'b0;
        tick();

        // 1: basic allocation table
        for (int i = 0; i < 7; i++) begin
            do_alloc(int'(vecs[i].qid), int'(vecs[i].len), vecs[i].exp_ready, vecs[i].exp_addr,
                     vecs[i].name);
        end

        i_rst = 1'b1; tick(); i_rst = 1'b0; tick();

        // 2: wrap with tail skip; pad is released by the read from base
        do_alloc(0, 126, 1'b1, rbase(0), "t2_fill");
        do_cpl(0, rbase(0), 126, 8'hFF);
        run_read(0, 2000, 1, 1008, "t2_rd0");
        do_alloc(0, 4, 1'b1, rbase(0), "t2_wrap");
        do_cpl(0, rbase(0), 4, 8'hFF);
        run_read(0, 32, 1, 32, "t2_rd1");
        do_alloc(0, 122, 1'b1, rbase(0) + 'h20, "t2_after");
        do_alloc(0, 4, 1'b1, rbase(0), "t2_rewrap");

        // 3: region full back-pressure, freed by one read
        do_alloc(2, 64, 1'b1, rbase(2), "t3_a");
        do_alloc(2, 64, 1'b1, rbase(2) + 'h200, "t3_b");
        do_alloc(2, 64, 1'b0, '0, "t3_full");
        do_cpl(2, rbase(2), 64, 8'hFF);
        qsize_check("t3_size", 2, 'd512);
        run_read(2, 1518, 1, 512, "t3_rd");
        do_alloc(2, 64, 1'b1, rbase(2), "t3_reaccept");

        // 4: budget stops before third 64B descriptor
        for (int i = 0; i < 3; i++) do_alloc(1, 8, 1'b1, rbase(1) + W'(i * 'h40), "t4_alloc");
        for (int i = 0; i < 3; i++) do_cpl(1, rbase(1) + W'(i * 'h40), 8, 8'hFF);
        qsize_check("t4_size_pre", 1, 'd192);
        run_read(1, 150, 2, 128, "t4_rd");
        qsize_check("t4_size_post", 1, 'd64);

        // 5: stall with i_rd_ready low, then pop together with a completion on the same queue
        do_alloc(3, 8, 1'b1, rbase(3), "t5_a");
        do_alloc(3, 2, 1'b1, rbase(3) + 'h40, "t5_b");
        do_cpl(3, rbase(3), 8, 8'h0F);
        i_rd_ready = 1'b0;
        i_rd_budget_valid = 1'b1; i_rd_budget_qid = 2'd3; i_rd_budget_bytes = 'd70;
        tick();
        i_rd_budget_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t5_valid", 64'(o_rd_valid), 64'd1);
            check("t5_addr", 64'(o_rd_addr), 64'(rbase(3)));
            check("t5_len", 64'(o_rd_len), 64'd8);
            check("t5_strb", 64'(o_rd_strb), 64'h0F);
            check("t5_qid", 64'(o_rd_qid), 64'd3);
            tick();
        end
        i_rd_ready = 1'b1;
        i_wr_cpl_valid = 1'b1; i_wr_cpl_qid = 2'd3; i_wr_cpl_addr = rbase(3) + 'h40;
        i_wr_cpl_len = 16'd2; i_wr_cpl_strb = 8'h03;
        tick();
        i_wr_cpl_valid = 1'b0;
        qsize_check("t5_size_net", 3, 'd16);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                if (o_rd_done) begin
                    seen = 1'b1;
                    check("t5_dbytes", 64'(o_rd_done_bytes), 64'd64);
                end else begin
                    tick();
                end
            end
            check("t5_done_seen", 64'(seen), 64'd1);
        end
        tick();
        qsize_check("t5_size_end", 3, 'd16);

        // 6: reset while a descriptor is being offered
        i_rd_ready = 1'b0;
        i_rd_budget_valid = 1'b1; i_rd_budget_qid = 2'd1; i_rd_budget_bytes = 'd1000;
        tick();
        i_rd_budget_valid = 1'b0;
        tick();
        check("t6_valid_pre", 64'(o_rd_valid), 64'd1);
        i_rst = 1'b1;
        tick();
        check("t6_rvalid", 64'(o_rd_valid), 64'd0);
        check("t6_raddr", 64'(o_rd_addr), 64'd0);
        check("t6_bready", 64'(o_rd_budget_ready), 64'd1);
        check("t6_done", 64'(o_rd_done), 64'd0);
        check("t6_dbytes", 64'(o_rd_done_bytes), 64'd0);
        check("t6_avalid", 64'(o_wr_alloc_valid), 64'd0);
        check("t6_aaddr", 64'(o_wr_alloc_addr), 64'd0);
        check("t6_qsize", 64'(o_queue_size != '0), 64'd0);
        check("t6_cready", 64'(o_wr_cpl_ready), 64'd1);
        i_rst = 1'b0;
        i_rd_ready = 1'b1;
        tick();
        run_read(1, 1000, 0, 0, "t6_empty");
        do_alloc(1, 8, 1'b1, rbase(1), "t6_wptr");
        do_cpl(1, rbase(1), 8, 8'hFF);
        run_read(1, 0, 0, 0, "t6_budget0");
        qsize_check("t6_size_kept", 1, 'd64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
